// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  // Who is owed the response that returns in the cycle after a grant.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  // Requester slots in the round-robin request/grant vectors.
  localparam int REQ_IF = 0;
  localparam int REQ_LS = 1;

  // All-ones byte-enable pattern, wide enough for any sensible DATA_W;
  // users slice off the DATA_W/8 bits they need.
  localparam logic [127:0] BE_ALL = {128{1'b1}};

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Slot 0 is instruction fetch, slot 1 is
// load/store. On a contested cycle the slot that did not win the previous
// contested cycle is granted; uncontested cycles leave the history alone.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1'b1: load/store won the most recent contested cycle.
  logic       last_winner_r;
  logic [1:0] gnt_s;

  // Combinational grant; reset forces the arbiter idle.
  always_comb begin
    gnt_s = 2'b00;
    if (reset) begin
      gnt_s = 2'b00;
    end else begin
      case (req)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = last_winner_r ? 2'b01 : 2'b10;
        default: gnt_s = 2'b00;
      endcase
    end
  end

  assign gnt = gnt_s;

  // Remember the winner of contested cycles only; reset favours fetch next.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_r <= 1'b1;
    end else if (req == 2'b11) begin
      last_winner_r <= gnt_s[REQ_LS];
    end else begin
      last_winner_r <= last_winner_r;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported, 1-cycle-latency RAM between instruction fetch
// and load/store. Grants are combinational; the response owner is
// registered so read data can be steered back in the following cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  logic [1:0] req_s;
  logic [1:0] gnt_s;
  owner_t     resp_owner_r;
  logic       resp_is_store_r;

  // Byte-offset bits and bits above the RAM size are deliberately dropped:
  // misaligned accesses are not faulted and addresses wrap.
  logic unused_addr_s;
  assign unused_addr_s = ^{if_addr[1:0], if_addr[ADDR_W-1:MEM_AW+2],
                           ls_addr[1:0], ls_addr[ADDR_W-1:MEM_AW+2]};

  assign req_s = {ls_req, if_req};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .req   (req_s),
    .gnt   (gnt_s)
  );

  assign if_gnt = gnt_s[REQ_IF];
  assign ls_gnt = gnt_s[REQ_LS];

  // Drive the memory port from whichever requester holds the grant.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = {BE_W{1'b0}};
    mem_addr  = {MEM_AW{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (gnt_s[REQ_IF]) begin
      mem_en    = 1'b1;
      mem_we    = 1'b0;
      mem_be    = BE_ALL[BE_W-1:0];
      mem_addr  = if_addr[MEM_AW+1:2];
      mem_wdata = {DATA_W{1'b0}};
    end else if (gnt_s[REQ_LS]) begin
      mem_en    = 1'b1;
      mem_we    = ls_we;
      mem_be    = ls_be;
      mem_addr  = ls_addr[MEM_AW+1:2];
      mem_wdata = ls_wdata;
    end else begin
      mem_en    = 1'b0;
    end
  end

  // Record who owns the response arriving next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_owner_r    <= OWN_NONE;
      resp_is_store_r <= 1'b0;
    end else if (gnt_s[REQ_IF]) begin
      resp_owner_r    <= OWN_IF;
      resp_is_store_r <= 1'b0;
    end else if (gnt_s[REQ_LS]) begin
      resp_owner_r    <= OWN_LS;
      resp_is_store_r <= ls_we;
    end else begin
      resp_owner_r    <= OWN_NONE;
      resp_is_store_r <= 1'b0;
    end
  end

  // A response owed from before reset asserted is dropped, so reset also
  // masks the valid flags while it is high.
  assign if_rvalid = (resp_owner_r == OWN_IF) && !reset;
  assign ls_rvalid = (resp_owner_r == OWN_LS) && !reset;

  // Steer read data to the owner; stores and non-owners see zero.
  always_comb begin
    if_rdata = {DATA_W{1'b0}};
    ls_rdata = {DATA_W{1'b0}};
    if (!reset) begin
      case (resp_owner_r)
        OWN_IF:  if_rdata = mem_rdata;
        OWN_LS:  ls_rdata = resp_is_store_r ? {DATA_W{1'b0}} : mem_rdata;
        default: begin
          if_rdata = {DATA_W{1'b0}};
          ls_rdata = {DATA_W{1'b0}};
        end
      endcase
    end else begin
      if_rdata = {DATA_W{1'b0}};
      ls_rdata = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural RAM on the memory port, a shadow
// copy of its contents kept from the bench's own stimulus, and a queue of
// expected responses checked by a monitor on every falling edge.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MEM_AW = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [3:0]        ls_be;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata, ls_rdata;
  logic              mem_en, mem_we;
  logic [3:0]        mem_be;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] fill_word(input int i);
    logic [31:0] v;
    if (i == 1) return 32'h0120_8113;
    if (i == 4) return 32'h0000_0000;
    v = 32'(i) * 32'h9E37_79B9;
    return v ^ 32'h1357_2468;
  endfunction

  // Behavioural RAM; store cycles return junk so a missing store mask shows.
  logic [31:0] mem [0:1023];
  logic        init_mem;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= fill_word(i);
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= 32'hDEAD_BEEF;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    owner_t      owner;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [0:1023];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        mon_en = 1'b0;
  logic        exp_last_ls;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
  endtask

  task automatic sb_push(input owner_t o, input logic [31:0] d);
    exp_t e;
    e.owner = o; e.data = d; e.due = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    tick();
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_wdata = 32'h1234_5678;
    #1;
    n_cmp++;
    if ({if_gnt, ls_gnt, mem_en, mem_we} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_gnt: got %b want 0000", {if_gnt, ls_gnt, mem_en, mem_we});
    end
    n_cmp++;
    if ({mem_be, mem_addr, mem_wdata} !== 46'h0) begin
      n_bad++; $display("FAIL reset_mem: be=%h addr=%h wdata=%h want 0", mem_be, mem_addr, mem_wdata);
    end
    n_cmp++;
    if ({if_rvalid, ls_rvalid, if_rdata, ls_rdata} !== 66'h0) begin
      n_bad++; $display("FAIL reset_resp: rv=%b%b if_rdata=%h ls_rdata=%h want 0",
                        if_rvalid, ls_rvalid, if_rdata, ls_rdata);
    end
    tick();
    drive_idle();
    reset = 1'b0;
    mon_en = 1'b1;
    tick();
  endtask

  task automatic test_fetch_only();
    if_req = 1'b1; if_addr = 32'h4;
    #1;
    n_cmp++;
    if ({if_gnt, ls_gnt, mem_en, mem_we} !== 4'b1010) begin
      n_bad++; $display("FAIL fetch_gnt: got %b want 1010", {if_gnt, ls_gnt, mem_en, mem_we});
    end
    n_cmp++;
    if (mem_addr !== 10'd1 || mem_be !== 4'hF || mem_wdata !== 32'h0) begin
      n_bad++; $display("FAIL fetch_mem: addr=%0d be=%h wdata=%h want 1 f 0", mem_addr, mem_be, mem_wdata);
    end
    sb_push(OWN_IF, 32'h0120_8113);
    tick();
    drive_idle();
    #1;
    n_cmp++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h0120_8113 || ls_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL fetch_resp: if_rvalid=%b if_rdata=%h ls_rvalid=%b want 1 01208113 0",
                        if_rvalid, if_rdata, ls_rvalid);
    end
    tick();
  endtask

  task automatic test_store_load();
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h10; ls_wdata = 32'hAABB_CCDD;
    #1;
    n_cmp++;
    if ({ls_gnt, if_gnt, mem_en, mem_we} !== 4'b1011 || mem_be !== 4'b0011 ||
        mem_addr !== 10'd4 || mem_wdata !== 32'hAABB_CCDD) begin
      n_bad++; $display("FAIL store_mem: gnt/en/we=%b be=%b addr=%0d wdata=%h want 1011 0011 4 aabbccdd",
                        {ls_gnt, if_gnt, mem_en, mem_we}, mem_be, mem_addr, mem_wdata);
    end
    ref_mem[4][15:0] = 16'hCCDD;
    sb_push(OWN_LS, 32'h0);
    tick();
    ls_we = 1'b0; ls_be = 4'hF; ls_wdata = 32'h0;
    #1;
    n_cmp++;
    if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h0) begin
      n_bad++; $display("FAIL store_ack: ls_rvalid=%b ls_rdata=%h want 1 0", ls_rvalid, ls_rdata);
    end
    n_cmp++;
    if (ls_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd4) begin
      n_bad++; $display("FAIL load_mem: gnt=%b we=%b addr=%0d want 1 0 4", ls_gnt, mem_we, mem_addr);
    end
    sb_push(OWN_LS, 32'h0000_CCDD);
    tick();
    drive_idle();
    #1;
    n_cmp++;
    if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h0000_CCDD) begin
      n_bad++; $display("FAIL load_resp: ls_rvalid=%b ls_rdata=%h want 1 0000ccdd", ls_rvalid, ls_rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [31:0] if_pc  = 32'h20;
    logic [31:0] ls_ptr = 32'h100;
    logic        exp_if;
    logic [9:0]  w;
    for (int i = 0; i < 6; i++) begin
      if_req = 1'b1; if_addr = if_pc;
      ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = ls_ptr;
      #1;
      exp_if = exp_last_ls;
      w = exp_if ? if_pc[11:2] : ls_ptr[11:2];
      n_cmp++;
      if (if_gnt !== exp_if || ls_gnt !== !exp_if || mem_addr !== w) begin
        n_bad++; $display("FAIL contention_gnt[%0d]: if_gnt=%b ls_gnt=%b addr=%0d want %b %b %0d",
                          i, if_gnt, ls_gnt, mem_addr, exp_if, !exp_if, w);
      end
      sb_push(exp_if ? OWN_IF : OWN_LS, ref_mem[w]);
      exp_last_ls = !exp_if;
      if (exp_if) if_pc = if_pc + 32'd4;
      else        ls_ptr = ls_ptr + 32'd4;
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_wrap();
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h1004;
    #1;
    n_cmp++;
    if (ls_gnt !== 1'b1 || mem_addr !== 10'd1) begin
      n_bad++; $display("FAIL wrap_addr: gnt=%b addr=%0d want 1 1", ls_gnt, mem_addr);
    end
    sb_push(OWN_LS, 32'h0120_8113);
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h8;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'hC;
    #1;
    n_cmp++;
    if (if_gnt !== exp_last_ls || ls_gnt !== !exp_last_ls) begin
      n_bad++; $display("FAIL rstmid_gnt_n: if_gnt=%b ls_gnt=%b want %b %b",
                        if_gnt, ls_gnt, exp_last_ls, !exp_last_ls);
    end
    exp_last_ls = 1'b0;
    tick();
    drive_idle();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'h0 || ls_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_n1: if_rvalid=%b if_rdata=%h ls_rvalid=%b want 0 0 0",
                        if_rvalid, if_rdata, ls_rvalid);
    end
    tick();
    reset = 1'b0;
    exp_last_ls = 1'b1;
    if_req = 1'b1; if_addr = 32'h8;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'hC;
    #1;
    n_cmp++;
    if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_n2: if_rvalid=%b ls_rvalid=%b want 0 0", if_rvalid, ls_rvalid);
    end
    n_cmp++;
    if (if_gnt !== 1'b1 || ls_gnt !== 1'b0 || mem_addr !== 10'd2) begin
      n_bad++; $display("FAIL rstmid_first: if_gnt=%b ls_gnt=%b addr=%0d want 1 0 2",
                        if_gnt, ls_gnt, mem_addr);
    end
    sb_push(OWN_IF, ref_mem[2]);
    exp_last_ls = 1'b0;
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_idle();
    drive_idle();
    #1;
    n_cmp++;
    if ({if_gnt, ls_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== 50'h0) begin
      n_bad++; $display("FAIL idle_mem: gnt=%b%b en=%b we=%b be=%h addr=%h wdata=%h want 0",
                        if_gnt, ls_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
    end
    tick();
    n_cmp++;
    if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL idle_resp: rvalid=%b%b want 00", if_rvalid, ls_rvalid);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests incomplete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    init_mem = 1'b1;
    exp_last_ls = 1'b1;
    drive_idle();
    for (int i = 0; i < 1024; i++) ref_mem[i] = fill_word(i);

    // Scoreboard monitor: every falling edge, the head entry due this cycle
    // (if any) defines the only response allowed on the bus.
    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          logic        want_if, want_ls;
          logic [31:0] want_if_d, want_ls_d;
          exp_t        e;
          want_if = 1'b0; want_ls = 1'b0; want_if_d = 32'h0; want_ls_d = 32'h0;
          if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.owner == OWN_IF) begin want_if = 1'b1; want_if_d = e.data; end
            if (e.owner == OWN_LS) begin want_ls = 1'b1; want_ls_d = e.data; end
          end
          n_cmp++;
          if (if_rvalid !== want_if || ls_rvalid !== want_ls) begin
            n_bad++; $display("FAIL sb_rvalid@%0d: if=%b ls=%b want %b %b",
                              cyc, if_rvalid, ls_rvalid, want_if, want_ls);
          end
          n_cmp++;
          if (if_rdata !== want_if_d || ls_rdata !== want_ls_d) begin
            n_bad++; $display("FAIL sb_rdata@%0d: if=%h ls=%h want %h %h",
                              cyc, if_rdata, ls_rdata, want_if_d, want_ls_d);
          end
        end
      end
    join_none

    tick();
    init_mem = 1'b0;
    test_reset();
    test_fetch_only();
    test_store_load();
    test_contention();
    test_wrap();
    test_reset_mid();
    test_idle();
    tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL sb_drain: %0d responses outstanding, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one single-ported synchronous memory between the core's instruction-fetch unit and its load/store unit. It sits between the core pipeline and a unified instruction/data RAM of 1024 words. It grants at most one access per cycle with round-robin fairness, and routes each 1-cycle-latency response back to the requester that issued it.

## Interface
- `ADDR_W`, 32: byte-address width of requester ports.
- `DATA_W`, 32: data width; byte enables are `DATA_W/8` bits.
- `MEM_AW`, 10: word-address width of the memory port (1024 words).

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held until granted.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_gnt`  out  1  fetch granted this cycle (combinational).
- `if_rvalid`  out  1  fetch response valid (registered).
- `if_rdata`  out  DATA_W  fetch read data.
- `ls_req`  in  1  load/store request; held until granted.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_be`  in  DATA_W/8  store byte enables.
- `ls_addr`  in  ADDR_W  load/store byte address.
- `ls_wdata`  in  DATA_W  store data.
- `ls_gnt`  out  1  load/store granted this cycle (combinational).
- `ls_rvalid`  out  1  load/store response valid; also the store acknowledge.
- `ls_rdata`  out  DATA_W  load data; 0 for store responses.
- `mem_en`  out  1  memory access this cycle.
- `mem_we`  out  1  memory write.
- `mem_be`  out  DATA_W/8  memory byte enables.
- `mem_addr`  out  MEM_AW  memory word address = `addr[MEM_AW+1:2]`.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid one cycle after `mem_en`.

## Operation
- **Arbitration (combinational):**
  - Only one requester active: it is granted.
  - Both active: grant the requester that did not win the most recent contested cycle.
  - Neither active: no grant, `mem_en`=0.
- **`last_winner` register:** updated only on contested cycles.
- **Forced idle:** when `reset`=1, both grants are forced to 0 and `mem_en`=0.
- **Memory drive on grant:**
  - `mem_en`=1.
  - `mem_addr`, `mem_we`, `mem_be`, `mem_wdata` come from the winner.
  - Fetch grant: `mem_we`=0, `mem_be`=all-ones, `mem_wdata`=0.
  - Idle cycle: all memory outputs are 0.
- **Address handling:**
  - Low two address bits are ignored; misaligned addresses are not faulted.
  - Address bits above `MEM_AW+1` are ignored, so accesses wrap modulo 1024 words.
- **Response routing:**
  - Registered `resp_owner` ∈ {NONE, IF, LS} and `resp_is_store`, captured from the grant.
  - Next cycle the owner's `rvalid`=1.
  - `if_rdata` = `mem_rdata`.
  - `ls_rdata` = `mem_rdata` for a load, 0 for a store.
  - The non-owner's `rdata` is 0.
- **Pipelining:** a new grant may be issued in the same cycle a response returns; back-to-back accesses sustain one per cycle.
- **Requester rule:** `req`, `addr`, `we`, `be`, `wdata` must be stable from assertion until `gnt`. A requester may deassert `req` only after `gnt`. The arbiter does not check this.
- **Reset values:**
  - `if_gnt`=`ls_gnt`=0.
  - `if_rvalid`=`ls_rvalid`=0.
  - Both `rdata`=0.
  - All `mem_*` outputs 0.
  - `last_winner`=LS, so fetch wins the first contested cycle.
  - `resp_owner`=NONE.
- **Reset mid-operation:** a response owed from the cycle before reset is dropped; no `rvalid` appears in the cycle after reset deasserts.

## Timing
- Grant latency: 0 cycles. `gnt` is in the same cycle as `req` when uncontested; at most 1 cycle of wait when contested.
- Response latency: exactly 1 cycle after `gnt`, with `rvalid` high for exactly one cycle per grant.
- Throughput: 1 access/cycle total. Under continuous contention each requester gets one grant every 2 cycles, alternating.
- Combinational paths:
  - `req` → `gnt` → `mem_*`.
  - `mem_rdata` → `rdata`.
- No combinational path from `mem_rdata` to any grant.

## Structure
- Package `mem_arb_pkg`:
  - enum `owner_t` {OWN_NONE, OWN_IF, OWN_LS}.
  - constant `BE_ALL`.
- Sub-module `rr_arb2`: 2-way round-robin arbiter with `clk`, `reset`, `req[1:0]`, `gnt[1:0]` and internal `last_winner`.
- Muxing and response routing live in `mem_arbiter`.

## Test plan
- **Fetch only:** `if_req`=1, `if_addr`=0x4; memory word 1 = 0x01208113.
  - `if_gnt`=1 and `mem_addr`=1 in the same cycle.
  - Next cycle `if_rvalid`=1, `if_rdata`=0x01208113, `ls_rvalid`=0.
- **Store then load:**
  - Store: `ls_we`=1, `ls_be`=4'b0011, addr 0x10, wdata 0xAABBCCDD over word 0x0. Response: `ls_rvalid`=1, `ls_rdata`=0.
  - Following load of 0x10 returns 0x0000CCDD.
- **Continuous contention for 6 cycles:**
  - Grants alternate IF, LS, IF, LS, IF, LS.
  - Each `rvalid` goes to the matching requester one cycle later.
- **Wrap-around:** load from 0x1004 returns memory word 1 (`mem_addr`=1).
- **Reset mid-operation:**
  - Fetch granted at cycle N, `reset`=1 at cycle N+1.
  - `if_rvalid`=0 at N+1 and N+2.
  - After reset, a simultaneous request grants IF first.
- **Idle cycle:** no requests → `mem_en`=0, all `mem_*`=0, both `rvalid`=0 next cycle.
